// File: rtl/cpu_clock_control_if.sv
// Pushbutton inputs and count-enable outputs between the board controls and the PC stage.
// HALT_REQ exists only when CPU_CLK_CTRL_HALT_REQ_EN is defined.
interface cpu_clock_control_if;
    logic       BTN_STEP;
    logic       BTN_MODE;
    logic       CE;
    logic       MODE_RUN;
    logic [7:0] CE_COUNT;
`ifdef CPU_CLK_CTRL_HALT_REQ_EN
    logic       HALT_REQ;

    modport master (output BTN_STEP, BTN_MODE, HALT_REQ, input CE, MODE_RUN, CE_COUNT);
    modport slave  (input BTN_STEP, BTN_MODE, HALT_REQ, output CE, MODE_RUN, CE_COUNT);
`else
    modport master (output BTN_STEP, BTN_MODE, input CE, MODE_RUN, CE_COUNT);
    modport slave  (input BTN_STEP, BTN_MODE, output CE, MODE_RUN, CE_COUNT);
`endif
endinterface

// File: rtl/cpu_clock_control.sv
// Run/halt/single-step control generating the program counter's count-enable from CLK_50.
// Optional HALT_REQ input (halt instruction hook) enabled by defining CPU_CLK_CTRL_HALT_REQ_EN.
module cpu_clock_control #(
    parameter int unsigned TICK_DIV        = 25000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               CLK_50,
    input  logic               RESET,
    cpu_clock_control_if.slave bus
);
    localparam int unsigned      DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       press_step;
    logic       press_mode;
    logic       halt_req;

    assign btn_raw    = {bus.BTN_MODE, bus.BTN_STEP};
    assign press_step = press[0];
    assign press_mode = press[1];

`ifdef CPU_CLK_CTRL_HALT_REQ_EN
    assign halt_req = bus.HALT_REQ;
`else
    assign halt_req = 1'b0;
`endif

    // Per button: 2-flop synchronizer, stability counter, and a registered 1->0 press pulse.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic            sync_a;
        logic            sync_b;
        logic            level;
        logic            press_q;
        logic [DB_W-1:0] db_cnt;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge CLK_50 or posedge RESET) begin
            if (RESET) begin
                // NOTE: synchronizer and debounced level reset to the released (high) level.
                sync_a  <= 1'b1;
                sync_b  <= 1'b1;
                level   <= 1'b1;
                press_q <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync_a  <= btn_raw[g];
                sync_b  <= sync_a;
                press_q <= 1'b0;
                if (sync_b == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level   <= sync_b;
                    db_cnt  <= '0;
                    press_q <= level;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign press[g] = press_q;
    end

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_d;
    logic             ce_d;
    logic             ce_q;
    logic             mode_run_q;
    logic [7:0]       ce_count_q;

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state;
        div_d   = div;
        ce_d    = 1'b0;
        case (state)
            S_HALT: begin
                if (press_mode) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end else if (press_step) begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end
            end
            S_STEP: state_d = S_HALT;
            S_RUN: begin
                // A halt request or mode press wins over a tick that is due this cycle.
                if (halt_req || press_mode) begin
                    state_d = S_HALT;
                    div_d   = '0;
                end else if (div == DIV_LAST) begin
                    div_d = '0;
                    ce_d  = 1'b1;
                end else begin
                    div_d = div + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_HALT;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= S_HALT;
            div        <= '0;
            ce_q       <= 1'b0;
            mode_run_q <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state      <= state_d;
            div        <= div_d;
            ce_q       <= ce_d;
            mode_run_q <= (state_d == S_RUN);
            ce_count_q <= ce_count_q + 8'(ce_d);
        end
    end

    assign bus.CE       = ce_q;
    assign bus.MODE_RUN = mode_run_q;
    assign bus.CE_COUNT = ce_count_q;
endmodule

// File: tb/tb_cpu_clock_control.sv
// Directed bench for cpu_clock_control (TICK_DIV=4, DEBOUNCE_CYCLES=3) with a CE scoreboard.
// Define CPU_CLK_CTRL_HALT_REQ_EN to also exercise HALT_REQ.
module tb_cpu_clock_control;
    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    logic CLK_50 = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t exp_q[$];
    exp_t mon_e;

    cpu_clock_control_if bus();

    cpu_clock_control #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .CLK_50 (CLK_50),
        .RESET  (RESET),
        .bus    (bus)
    );

    always #5 CLK_50 = ~CLK_50;
    always @(posedge CLK_50) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expd, cyc);
    endtask

    task automatic push_ce(input int c);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back('{c, exp_cnt});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK_50);
    endtask

    // Scoreboard: every CE must match the next expected cycle and count.
    always @(negedge CLK_50) begin
        if (RESET === 1'b0 && bus.CE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ce_unexpected", 32'(bus.CE), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ce_cycle", cyc, mon_e.cyc);
                check("ce_count", 32'(bus.CE_COUNT), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        int k;
        int e;
        RESET        = 1'b1;
        bus.BTN_STEP = 1'b1;
        bus.BTN_MODE = 1'b1;
`ifdef CPU_CLK_CTRL_HALT_REQ_EN
        bus.HALT_REQ = 1'b0;
`endif
        #1;
        check("rst_ce", 32'(bus.CE), 32'd0);
        check("rst_mode_run", 32'(bus.MODE_RUN), 32'd0);
        check("rst_ce_count", 32'(bus.CE_COUNT), 32'd0);
        repeat (2) @(negedge CLK_50);
        RESET = 1'b0;

        repeat (50) begin
            @(negedge CLK_50);
            check("idle_ce", 32'(bus.CE), 32'd0);
            check("idle_mode_run", 32'(bus.MODE_RUN), 32'd0);
            check("idle_ce_count", 32'(bus.CE_COUNT), 32'd0);
        end

        // Single step: CE exactly 6 cycles after the raw falling edge.
        k = cyc;
        bus.BTN_STEP = 1'b0;
        push_ce(k + 6);
        wait_until(k + 7);
        check("step_single_cycle", 32'(bus.CE), 32'd0);
        check("step_back_to_halt", 32'(bus.MODE_RUN), 32'd0);
        wait_until(k + 20);
        bus.BTN_STEP = 1'b1;
        repeat (10) @(negedge CLK_50);
        check("step_count", 32'(bus.CE_COUNT), 32'd1);

        // Bouncing contact never stays stable long enough to be accepted.
        repeat (10) begin
            bus.BTN_STEP = ~bus.BTN_STEP;
            @(negedge CLK_50);
        end
        bus.BTN_STEP = 1'b1;
        repeat (10) @(negedge CLK_50);
        check("bounce_count", 32'(bus.CE_COUNT), 32'd1);
        check("bounce_queue", exp_q.size(), 32'd0);

        RESET = 1'b1;
        exp_cnt = 8'd0;
        @(negedge CLK_50);
        RESET = 1'b0;
        check("rst2_ce_count", 32'(bus.CE_COUNT), 32'd0);

        // RUN: first CE TICK_DIV cycles after entry, then every TICK_DIV cycles.
        k = cyc;
        bus.BTN_MODE = 1'b0;
        e = k + 6;
        for (int i = 1; i <= 260; i++) push_ce(e + 4 * i);
        wait_until(e - 1);
        check("run_entry_before", 32'(bus.MODE_RUN), 32'd0);
        wait_until(e);
        check("run_entry", 32'(bus.MODE_RUN), 32'd1);
        wait_until(k + 10);
        bus.BTN_MODE = 1'b1;

        wait_until(e + 100);
        bus.BTN_STEP = 1'b0;
        wait_until(e + 110);
        bus.BTN_STEP = 1'b1;

        wait_until(e + 4 * 64);
        check("run_64", 32'(bus.CE_COUNT), 32'd64);
        wait_until(e + 4 * 255);
        check("run_255", 32'(bus.CE_COUNT), 32'd255);
        wait_until(e + 4 * 256);
        check("run_wrap", 32'(bus.CE_COUNT), 32'd0);

        // Mode press whose pulse coincides with divider==3: the due tick is dropped.
        wait_until(e + 4 * 260 - 2);
        bus.BTN_MODE = 1'b0;
        wait_until(e + 4 * 261);
        check("halt_no_ce", 32'(bus.CE), 32'd0);
        check("halt_mode_run", 32'(bus.MODE_RUN), 32'd0);
        wait_until(e + 4 * 261 + 4);
        bus.BTN_MODE = 1'b1;
        wait_until(e + 4 * 261 + 20);
        check("halt_queue", exp_q.size(), 32'd0);
        check("halt_count", 32'(bus.CE_COUNT), 32'(exp_cnt));

        // Asynchronous reset between clock edges while running.
        k = cyc;
        bus.BTN_MODE = 1'b0;
        e = k + 6;
        for (int i = 1; i <= 3; i++) push_ce(e + 4 * i);
        wait_until(k + 10);
        bus.BTN_MODE = 1'b1;
        wait_until(e + 13);
        check("pre_reset_count", 32'(bus.CE_COUNT), 32'(exp_cnt));
        check("pre_reset_mode", 32'(bus.MODE_RUN), 32'd1);
        @(posedge CLK_50);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_mode_run", 32'(bus.MODE_RUN), 32'd0);
        check("async_rst_ce_count", 32'(bus.CE_COUNT), 32'd0);
        check("async_rst_ce", 32'(bus.CE), 32'd0);
        exp_cnt = 8'd0;
        @(negedge CLK_50);
        RESET = 1'b0;
        check("async_rst_queue", exp_q.size(), 32'd0);

`ifdef CPU_CLK_CTRL_HALT_REQ_EN
        // HALT_REQ in RUN halts on the next edge and suppresses the due tick.
        k = cyc;
        bus.BTN_MODE = 1'b0;
        e = k + 6;
        push_ce(e + 4);
        wait_until(k + 10);
        bus.BTN_MODE = 1'b1;
        wait_until(e + 7);
        bus.HALT_REQ = 1'b1;
        @(negedge CLK_50);
        bus.HALT_REQ = 1'b0;
        check("halt_req_ce", 32'(bus.CE), 32'd0);
        check("halt_req_mode_run", 32'(bus.MODE_RUN), 32'd0);
        repeat (10) @(negedge CLK_50);
        check("halt_req_count", 32'(bus.CE_COUNT), 32'd1);
`endif

        repeat (10) @(negedge CLK_50);
        check("final_queue", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
